// File: rtl/popcount_tnn_seq_if.sv
// ---------------------------------------------------------------------------
// popcount_tnn_seq_if
// Bundles the chunk input handshake, the external popcount unit connection
// and the activation output handshake of popcount_tnn_seq.
//   master : environment side (chunk source, popcount unit, result sink)
//   slave  : the sequencer itself
// Signals:
//   in_valid/in_ready, in_pos, in_neg, in_last, thresh : chunk input
//   pc_operand / pc_result                             : popcount unit
//   out_valid/out_ready, out_act, out_sum              : activation output
// ---------------------------------------------------------------------------
interface popcount_tnn_seq_if #(
    parameter int ACC_W = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [30:0]             in_pos;
    logic [30:0]             in_neg;
    logic                    in_last;
    logic signed [ACC_W-1:0] thresh;
    logic [30:0]             pc_operand;
    logic [4:0]              pc_result;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_act;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_pos, in_neg, in_last, thresh, pc_result, out_ready,
        input  in_ready, pc_operand, out_valid, out_act, out_sum
    );

    modport slave (
        input  in_valid, in_pos, in_neg, in_last, thresh, pc_result, out_ready,
        output in_ready, pc_operand, out_valid, out_act, out_sum
    );
endinterface

// File: rtl/popcount_tnn_seq.sv
// ---------------------------------------------------------------------------
// popcount_tnn_seq
// Time-shares one external 31-input popcount unit to evaluate a ternary
// neuron over up to CHUNKS chunks. Each chunk takes three cycles: accept
// (IDLE), positive popcount (POS), negative popcount (NEG). The signed,
// saturating sum is compared to the threshold captured on the neuron's
// first chunk and the activation is offered on a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - popcount_tnn_seq_if.slave (chunk in, popcount unit, result out)
// ---------------------------------------------------------------------------
module popcount_tnn_seq #(
    parameter int CHUNKS = 4,
    parameter int ACC_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    popcount_tnn_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, POS, NEG, OUT} state_e;

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    // Two guard bits so acc +/- 31 never wraps before clamping.
    localparam int EW = ACC_W + 2;
    localparam logic signed [EW-1:0] SMAX = EW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] thr_q;
    logic signed [ACC_W-1:0] out_sum_q;
    logic [CW-1:0]           cnt_q;
    logic                    first_q;
    logic [30:0]             pos_q;
    logic [30:0]             neg_q;
    logic                    last_q;
    logic                    out_valid_q;
    logic                    out_act_q;

    logic signed [EW-1:0]    acc_ext;
    logic signed [EW-1:0]    pc_ext;
    logic signed [EW-1:0]    sum_raw;
    logic signed [ACC_W-1:0] acc_d;

    // Saturating add in POS, saturating subtract in NEG. pc_result is
    // always taken as unsigned, even from an approximate unit.
    always_comb begin
        acc_ext = {{(EW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        pc_ext  = {{(EW-5){1'b0}}, bus.pc_result};
        sum_raw = (state_q == POS) ? (acc_ext + pc_ext) : (acc_ext - pc_ext);
        if (sum_raw > SMAX)
            acc_d = SMAX[ACC_W-1:0];
        else if (sum_raw < SMIN)
            acc_d = SMIN[ACC_W-1:0];
        else
            acc_d = sum_raw[ACC_W-1:0];
    end

    // Operand is parked at zero whenever the popcount result is unused.
    always_comb begin
        case (state_q)
            POS:     bus.pc_operand = pos_q;
            NEG:     bus.pc_operand = neg_q;
            default: bus.pc_operand = '0;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_act   = out_act_q;
    assign bus.out_sum   = out_sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            pos_q       <= '0;
            neg_q       <= '0;
            last_q      <= 1'b0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            out_act_q   <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        pos_q   <= bus.in_pos;
                        neg_q   <= bus.in_neg;
                        // The CHUNKS-th chunk closes the neuron even without in_last.
                        last_q  <= bus.in_last | (cnt_q == CW'(CHUNKS - 1));
                        if (first_q) begin
                            thr_q <= bus.thresh;
                            acc_q <= '0;
                        end
                        first_q <= 1'b0;
                        state_q <= POS;
                    end
                end
                POS: begin
                    acc_q   <= acc_d;
                    state_q <= NEG;
                end
                NEG: begin
                    acc_q <= acc_d;
                    if (last_q) begin
                        out_sum_q   <= acc_d;
                        out_act_q   <= (acc_d >= thr_q);
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        first_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/popcount_tnn_seq.md
Name: popcount_tnn_seq

Overview:
- Sequencer that time-shares one 31-input popcount unit (exact or approximate popcount31 variant) to evaluate one ternary neuron over up to CHUNKS 31-bit input chunks.
- Each chunk carries a positive-weight hit vector and a negative-weight hit vector. The block presents them to the popcount unit on successive cycles and accumulates pos minus neg as a signed sum.
- After the last chunk it compares the sum against a threshold and emits the activation over a valid/ready handshake.
- Sits between the on-sensor input buffer and the neuron output register.

Parameters:
- CHUNKS, 4, maximum chunks per neuron evaluation; a neuron ends at in_last or at the CHUNKS-th chunk, whichever comes first.
- ACC_W, 9, signed accumulator/threshold width; must satisfy 2^(ACC_W-1)-1 >= 31*CHUNKS.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  chunk available.
- in_ready  output  1  block accepts a chunk this cycle.
- in_pos  input  31  positive-weight hit bits of the chunk.
- in_neg  input  31  negative-weight hit bits of the chunk.
- in_last  input  1  final chunk of this neuron.
- thresh  input  ACC_W  signed threshold; sampled on the first chunk of a neuron.
- pc_operand  output  31  vector driven into the external combinational popcount unit.
- pc_result  input  5  popcount unit result for pc_operand, same cycle.
- out_valid  output  1  activation/sum valid.
- out_ready  input  1  downstream accepts the result.
- out_act  output  1  1 when sum >= thresh (signed compare).
- out_sum  output  ACC_W  signed accumulated sum.

Behaviour:
Reset (rst=1 at a clock edge, from any state, including mid-neuron):
- state=IDLE; acc=0, chunk_cnt=0, first=1.
- pos_reg=0, neg_reg=0, last_reg=0, thr_reg=0.
- out_valid=0, out_act=0, out_sum=0.
- in_ready=0 during the reset cycle. Any partial neuron is discarded.

FSM states: IDLE, POS, NEG, OUT.
- IDLE:
  - in_ready=1 and pc_operand=0.
  - On in_valid: latch in_pos, in_neg, and last_reg = in_last | (chunk_cnt==CHUNKS-1).
  - If first=1, also latch thr_reg=thresh and load acc=0.
  - Then clear first and go to POS.
- POS:
  - pc_operand=pos_reg; in_ready=0.
  - At the edge: acc = sat(acc + zero-extended pc_result); go to NEG.
- NEG:
  - pc_operand=neg_reg.
  - At the edge: acc = sat(acc - pc_result).
  - If last_reg: register out_sum=sat result, out_act=(sat result >= thr_reg), out_valid=1, and go to OUT.
  - Otherwise increment chunk_cnt and return to IDLE.
- OUT:
  - pc_operand=0; in_ready=0; outputs held stable.
  - When out_ready=1: out_valid=0, chunk_cnt=0, first=1, go to IDLE.
  - out_act and out_sum keep their last value after the handshake.

Arithmetic and data rules:
- sat clamps to the range [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
- pc_result is treated as unsigned 0..31 regardless of popcount approximation error. An approximate unit may return values above the true count; saturation covers the resulting overflow.
- pc_operand is 0 whenever the popcount result is unused (IDLE, OUT), to minimise switching.

Timing and handshake:
- Throughput is 3 cycles per chunk, so in_ready can rise again at the earliest 3 cycles after an accept.
- Latency from the last chunk accept to out_valid is 3 cycles.
- The next neuron's first chunk can be accepted in the cycle after the out handshake, not the same cycle.
- in_valid while in_ready=0 is ignored; the source must hold its data.
- in_last=0 on the CHUNKS-th chunk still terminates the neuron; the next chunk starts a new neuron.

Test Plan:
1. Single chunk: in_pos=0x7FFFFFFF (31), in_neg=0x0000000F (4), in_last=1, thresh=20, exact popcount model -> out_valid 3 cycles after accept; out_sum=27, out_act=1.
2. Three chunks, thresh=-5; pos counts 1,0,2; neg counts 3,4,2 -> out_sum=-6, out_act=0. Also check in_ready low for exactly 2 cycles after each accept and thresh changes after chunk 1 are ignored.
3. CHUNKS=4, in_last never asserted, 5 chunks sent -> result issued after the 4th chunk; the 5th chunk begins a new neuron with acc=0.
4. Backpressure: out_ready=0 for 10 cycles -> out_valid, out_sum and out_act stable, in_ready=0 throughout. Then out_ready=1 -> out_valid drops next edge and in_ready=1.
5. Saturation with ACC_W=7, CHUNKS=4, four chunks of pos=31, neg=0 -> out_sum=63, not wrapped; out_act=1 for thresh=63.
6. rst asserted in NEG of chunk 2 -> next edge state IDLE, outputs 0. A new single chunk (pos=5, neg=1) then gives out_sum=4, with no residue from the aborted neuron.
